// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised synchronous FIFO with level, thresholds, sticky errors and flush
// Full DEPTH usage via a separate level register; show-ahead or registered read port.
module fifo_sync_param #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 4,
  parameter int AFULL_TH  = 2**AWIDTH - 2,
  parameter int AEMPTY_TH = 1,
  parameter bit FWFT      = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] data_out,
  output logic              f_full,
  output logic              f_empty,
  output logic              f_almost_full,
  output logic              f_almost_empty,
  output logic [AWIDTH:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_LVL  = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AFULL_LVL  = (AWIDTH+1)'(AFULL_TH);
  localparam logic [AWIDTH:0] AEMPTY_LVL = (AWIDTH+1)'(AEMPTY_TH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;

  // Flags come from the registered level only, so there is no input-to-flag path.
  assign f_full         = (level_q == DEPTH_LVL);
  assign f_empty        = (level_q == '0);
  assign f_almost_full  = (level_q >= AFULL_LVL);
  assign f_almost_empty = (level_q <= AEMPTY_LVL);
  assign level          = level_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

  assign wr_acc = wr_en && !f_full && !flush;
  assign rd_acc = rd_en && !f_empty && !flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AWIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + (AWIDTH+1)'(1);
        2'b01:   level_d = level_q - (AWIDTH+1)'(1);
        default: level_d = level_q;
      endcase
      if (wr_en && f_full)  overflow_d  = 1'b1;
      if (rd_en && f_empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; a write is suppressed while reset is held low.
  always_ff @(posedge clock) begin
    if (wr_acc && reset) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT) begin : g_show_ahead
      assign data_out = f_empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_registered
      logic [DWIDTH-1:0] rdata_q;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset)      rdata_q <= '0;
        else if (rd_acc) rdata_q <= mem_q[rd_ptr_q];
      end
      assign data_out = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed self-checking bench for fifo_sync_param
// Instance a is show-ahead, instance b uses the registered read port.
module tb_fifo_sync_param;

  logic       clock = 1'b0;
  logic       clk_run = 1'b1;
  logic       reset = 1'b0;

  logic       a_flush = 0, a_wr = 0, a_rd = 0;
  logic [7:0] a_din = '0, a_dout;
  logic       a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
  logic [2:0] a_level;

  logic       b_flush = 0, b_wr = 0, b_rd = 0;
  logic [7:0] b_din = '0, b_dout;
  logic       b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
  logic [2:0] b_level;

  int checks = 0;
  int errors = 0;

  always begin
    #5;
    if (clk_run) clock = ~clock;
    else         clock = 1'b0;
  end

  fifo_sync_param #(.DWIDTH(8), .AWIDTH(2), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1'b1)) u_a (
    .clock(clock), .reset(reset), .flush(a_flush), .wr_en(a_wr), .data_in(a_din),
    .rd_en(a_rd), .data_out(a_dout), .f_full(a_full), .f_empty(a_empty),
    .f_almost_full(a_afull), .f_almost_empty(a_aempty), .level(a_level),
    .overflow(a_ovf), .underflow(a_udf)
  );

  fifo_sync_param #(.DWIDTH(8), .AWIDTH(2), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1'b0)) u_b (
    .clock(clock), .reset(reset), .flush(b_flush), .wr_en(b_wr), .data_in(b_din),
    .rd_en(b_rd), .data_out(b_dout), .f_full(b_full), .f_empty(b_empty),
    .f_almost_full(b_afull), .f_almost_empty(b_aempty), .level(b_level),
    .overflow(b_ovf), .underflow(b_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // level, full, empty, almost_full, almost_empty, overflow, underflow of instance a
  task automatic chk_a(input string tag, input logic [2:0] lvl, input logic [5:0] fl);
    chk({tag, ".level"}, 32'(a_level), 32'(lvl));
    chk({tag, ".flags"}, 32'({a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf}), 32'(fl));
  endtask

  initial begin
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33; exp_rd[3] = 8'h44;

    #12;
    // flags order: full empty afull aempty ovf udf
    chk_a("reset", 3'd0, 6'b010100);
    chk("reset.dout", 32'(a_dout), 32'h0);
    chk("reset.b_dout", 32'(b_dout), 32'h0);
    step();
    reset = 1'b1;

    a_wr = 1; a_din = 8'h11; step();
    chk_a("w1", 3'd1, 6'b000100);
    chk("w1.dout", 32'(a_dout), 32'h11);
    a_din = 8'h22; step(); chk_a("w2", 3'd2, 6'b000000);
    a_din = 8'h33; step(); chk_a("w3", 3'd3, 6'b001000);
    a_din = 8'h44; step(); chk_a("w4", 3'd4, 6'b101000);
    a_din = 8'h55; step(); chk_a("w5_ovf", 3'd4, 6'b101010);
    chk("w5.dout", 32'(a_dout), 32'h11);

    a_wr = 0; a_rd = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d.dout", i), 32'(a_dout), 32'(exp_rd[i]));
      step();
    end
    chk_a("drained", 3'd0, 6'b010110);
    chk("drained.dout", 32'(a_dout), 32'h0);
    step();
    chk_a("rd5_udf", 3'd0, 6'b010111);

    a_rd = 0; a_wr = 1; a_din = 8'h66; step();
    chk_a("wrap", 3'd1, 6'b000111);
    chk("wrap.dout", 32'(a_dout), 32'h66);
    a_din = 8'h77; step();
    chk("lvl2", 32'(a_level), 32'd2);

    a_rd = 1;
    a_din = 8'h81; chk("sim0.dout", 32'(a_dout), 32'h66); step();
    a_din = 8'h82; chk("sim1.dout", 32'(a_dout), 32'h77); step();
    a_din = 8'h83; chk("sim2.dout", 32'(a_dout), 32'h81); step();
    chk_a("sim_lvl2", 3'd2, 6'b000011);
    chk("sim3.dout", 32'(a_dout), 32'h82);

    a_wr = 0; a_rd = 0; a_flush = 1; step();
    a_flush = 0;
    chk_a("flush_clr", 3'd0, 6'b010100);

    a_wr = 1; a_rd = 1; a_din = 8'h90; step();
    chk_a("both_empty", 3'd1, 6'b000101);
    chk("both_empty.dout", 32'(a_dout), 32'h90);

    a_flush = 1; step(); a_flush = 0;
    a_rd = 0;
    a_din = 8'h90; step();
    a_din = 8'h91; step();
    a_din = 8'h92; step();
    a_din = 8'h93; step();
    chk_a("refill", 3'd4, 6'b101000);
    a_rd = 1; a_din = 8'h94; step();
    chk_a("both_full", 3'd3, 6'b001010);
    chk("both_full.dout", 32'(a_dout), 32'h91);

    a_rd = 0; a_wr = 1; a_din = 8'hEE; a_flush = 1; step();
    a_flush = 0; a_wr = 0;
    chk_a("flush_wr", 3'd0, 6'b010100);
    chk("flush_wr.dout", 32'(a_dout), 32'h0);
    step();
    chk("flush_idle.level", 32'(a_level), 32'd0);

    a_wr = 1; a_din = 8'h12; step();
    a_din = 8'h13; step();
    a_din = 8'h14; step();
    chk("pre_rst.level", 32'(a_level), 32'd3);
    a_din = 8'h15;
    clk_run = 0;
    #12;
    reset = 1'b0;
    #3;
    chk_a("async_rst", 3'd0, 6'b010100);
    chk("async_rst.dout", 32'(a_dout), 32'h0);
    a_wr = 0;
    #3;
    reset = 1'b1;
    clk_run = 1;
    #2;
    a_wr = 1; a_din = 8'h21; step();
    a_wr = 0;
    chk_a("resume", 3'd1, 6'b000100);
    chk("resume.dout", 32'(a_dout), 32'h21);

    b_wr = 1; b_din = 8'hA5; step();
    b_din = 8'h5A; step();
    b_wr = 0;
    chk("b_w2.level", 32'(b_level), 32'd2);
    chk("b_w2.dout", 32'(b_dout), 32'h0);
    b_rd = 1; step();
    b_rd = 0;
    chk("b_rd1.dout", 32'(b_dout), 32'hA5);
    chk("b_rd1.level", 32'(b_level), 32'd1);
    step(); step();
    chk("b_hold.dout", 32'(b_dout), 32'hA5);
    b_rd = 1; step();
    b_rd = 0;
    chk("b_rd2.dout", 32'(b_dout), 32'h5A);
    b_rd = 1; step();
    b_rd = 0;
    chk("b_udf.dout", 32'(b_dout), 32'h5A);
    chk("b_udf.flag", 32'(b_udf), 32'h1);
    b_flush = 1; step();
    b_flush = 0;
    chk("b_flush.dout", 32'(b_dout), 32'h5A);
    chk("b_flush.udf", 32'(b_udf), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO, the next generation of the I2C master's transmit/receive buffer. It adds full use of all 2**AWIDTH entries, correct simultaneous read/write, an occupancy level and almost-full/almost-empty thresholds. It also provides sticky overflow/underflow error flags, a synchronous flush and a selectable show-ahead or registered read port. It sits between the register interface and the byte-level I2C engine; one instance is used per direction.

## Interface
- DWIDTH, 32, data word width in bits (>=1)
- AWIDTH, 4, address width; DEPTH = 2**AWIDTH entries, all usable (AWIDTH>=1)
- AFULL_TH, 2**AWIDTH-2, almost-full threshold; legal range 1..DEPTH
- AEMPTY_TH, 1, almost-empty threshold; legal range 0..DEPTH-1
- FWFT, 1, read mode: 1 = show-ahead (first-word-fall-through), 0 = registered read
- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of FIFO contents and error flags
- wr_en  input  1  write request
- data_in  input  DWIDTH  write data
- rd_en  input  1  read (pop) request
- data_out  output  DWIDTH  read data (see Operation)
- f_full  output  1  level == DEPTH
- f_empty  output  1  level == 0
- f_almost_full  output  1  level >= AFULL_TH
- f_almost_empty  output  1  level <= AEMPTY_TH
- level  output  AWIDTH+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a write was rejected because the FIFO was full
- underflow  output  1  sticky: a read was rejected because the FIFO was empty

## Operation
- Storage is a DEPTH x DWIDTH array. wr_ptr and rd_ptr are AWIDTH bits wide and wrap naturally from DEPTH-1 to 0. level is a separate AWIDTH+1-bit register.
- Write accepted = wr_en && !f_full && !flush. On acceptance: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1.
- Read accepted = rd_en && !f_empty && !flush. On acceptance: rd_ptr <= rd_ptr+1.
- Both ops are evaluated against the current-cycle flags. A write at full is rejected even when a read is accepted in the same cycle. A read at empty is rejected even when a write is accepted in the same cycle.
- Level update: write only gives +1; read only gives -1; both accepted or neither leaves level unchanged. level never exceeds DEPTH and never wraps below 0.
- Error flags: wr_en && f_full && !flush sets overflow. rd_en && f_empty && !flush sets underflow. Both flags hold until flush or reset.
- Flush has the highest priority after reset. It sets wr_ptr, rd_ptr and level to 0 and clears overflow and underflow. A wr_en/rd_en in the same cycle is ignored and sets no error flag. Memory contents are not cleared.
- FWFT=1: data_out = mem[rd_ptr] combinationally while !f_empty, and all-zeros while f_empty. rd_en acknowledges the word currently shown.
- FWFT=0: data_out is a register. On an accepted read, data_out <= mem[rd_ptr] and is valid the following cycle. Otherwise, including during flush, data_out holds its value.
- Status outputs f_full, f_empty, f_almost_full and f_almost_empty are decoded combinationally from the registered level only, never from wr_en or rd_en.

## Timing
- Reset (reset=0, asynchronous, applies immediately and independently of clock): wr_ptr=0, rd_ptr=0, level=0, overflow=0, underflow=0, data_out=0.
- Outputs immediately after reset: f_empty=1, f_full=0, f_almost_empty=1 (AEMPTY_TH>=0), f_almost_full=0. Memory contents are undefined and not reset.
- Reset asserted mid-operation discards all contents and pending ops. No accepted op completes on the edge where reset is low.
- Write-to-visibility: a word written at edge N raises level at N. With FWFT=1 into an empty FIFO, it appears on data_out after edge N, i.e. one cycle of latency.
- Read latency: FWFT=1 gives 0 cycles (data presented before rd_en). FWFT=0 gives 1 cycle after the accepting edge.
- Flags change only on clock edges: one cycle after the accepted op, flush or error, with no combinational path from inputs.
- Simultaneous read+write on a non-empty, non-full FIFO: both pointers advance, level is unchanged, and the flags are unchanged.

## Test plan
Unless stated, DWIDTH=8, AWIDTH=2 (DEPTH=4), AFULL_TH=3, AEMPTY_TH=1, FWFT=1.
- Fill: write 0x11,0x22,0x33,0x44 -> level=4, f_full=1, f_almost_full=1 (asserts at level 3). A fifth write of 0x55 -> rejected, overflow=1, level stays 4.
- Drain and wrap: from full, read 4 times -> data_out shows 0x11,0x22,0x33,0x44 in order, then f_empty=1 and data_out=0x00. A fifth read -> underflow=1. Write 0x66 -> stored at pointer index 0 after wrap and shown on data_out next cycle.
- Simultaneous ops:
  - at level=2, wr_en=rd_en=1 for 3 cycles -> level stays 2 and read order is preserved;
  - at level=0, both asserted -> write accepted, read rejected, underflow=1, level=1;
  - at level=4, both asserted -> read accepted, write rejected, overflow=1, level=3.
- Flush: at level=3 with overflow=1, assert flush together with wr_en -> next cycle level=0, f_empty=1, overflow=0, no write stored.
- Registered mode (FWFT=0): write 0xA5, then 0x5A, read once -> data_out=0xA5 one cycle after the read edge and holds while rd_en=0.
- Async reset: deassert clock, pulse reset low mid-burst at level=3 -> outputs go to their reset values without a clock edge. Normal operation resumes on the first edge after release.
